pe_dot_systolic: RTL

//  Next-generation processing element for the systolic MAC array. Accumulates

---
 rtl/pe_dot_systolic.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pe_dot_systolic.sv
// Systolic processing element: accumulates K activation*weight products, emits one result pulse,
// and forwards operands to neighbours. Define PE_SATURATE_EN for clamping accumulation with a sticky o_sat flag.
module pe_dot_systolic #(
    parameter int BW     = 8,
    parameter int ACC_W  = 24,
    parameter int K_W    = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [BW-1:0]    i_activation,
    input  logic [BW-1:0]    i_weight,
    input  logic [K_W-1:0]   i_k_len,
    input  logic             i_clear,
    output logic [BW-1:0]    o_activation,
    output logic [BW-1:0]    o_weight,
    output logic             o_valid,
    output logic [ACC_W-1:0] o_result,
    output logic             o_result_valid,
    output logic             o_busy,
    output logic             o_sat
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t            state_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [K_W-1:0]    cnt_reg;
    logic [K_W-1:0]    len_reg;
    logic              sat_reg;

    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic [K_W-1:0]    len_in;
    logic [K_W-1:0]    cnt_next;
    logic              beat_last;
    logic [ACC_W-1:0]  beat_val;
    logic              beat_ovf;

    generate
        if (SIGNED) begin : g_signed_prod
            logic signed [2*BW-1:0]  prod_s;
            logic signed [ACC_W-1:0] prod_wide;
            assign prod_s    = $signed(i_activation) * $signed(i_weight);
            assign prod_wide = prod_s;
            assign prod_ext  = prod_wide;
        end else begin : g_unsigned_prod
            logic [2*BW-1:0] prod_u;
            assign prod_u   = i_activation * i_weight;
            assign prod_ext = ACC_W'(prod_u);
        end
    endgenerate

    always_comb begin
        add_sum = acc_reg + prod_ext;
        add_ovf = 1'b0;
`ifdef PE_SATURATE_EN
        if (SIGNED) begin
            // Same-sign operands producing an opposite-sign sum is a signed overflow.
            if ((acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) && (add_sum[ACC_W-1] != acc_reg[ACC_W-1])) begin
                add_ovf = 1'b1;
                add_sum = acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            if (add_sum < acc_reg) begin
                add_ovf = 1'b1;
                add_sum = '1;
            end
        end
`endif
    end

    assign len_in    = (i_k_len == '0) ? K_W'(1) : i_k_len;
    assign cnt_next  = cnt_reg + K_W'(1);
    assign beat_last = (state_reg == IDLE) ? (len_in == K_W'(1)) : (cnt_next == len_reg);
    assign beat_val  = (state_reg == IDLE) ? prod_ext : add_sum;
    assign beat_ovf  = (state_reg == IDLE) ? 1'b0 : add_ovf;
    assign o_busy    = (state_reg == ACC);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_activation <= '0;
            o_weight     <= '0;
            o_valid      <= 1'b0;
        end else begin
            o_activation <= i_activation;
            o_weight     <= i_weight;
            o_valid      <= i_valid;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            len_reg        <= '0;
            sat_reg        <= 1'b0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_sat          <= 1'b0;
        end else begin
            o_result_valid <= 1'b0;
            o_sat          <= 1'b0;
            if (i_clear) begin
                state_reg <= IDLE;
                acc_reg   <= '0;
                cnt_reg   <= '0;
                sat_reg   <= 1'b0;
            end else if (i_valid) begin
                if (state_reg == IDLE) begin
                    len_reg <= len_in;
                end
                if (beat_last) begin
                    o_result       <= beat_val;
                    o_result_valid <= 1'b1;
                    o_sat          <= sat_reg | beat_ovf;
                    state_reg      <= IDLE;
                    acc_reg        <= '0;
                    cnt_reg        <= '0;
                    sat_reg        <= 1'b0;
                end else begin
                    state_reg <= ACC;
                    acc_reg   <= beat_val;
                    cnt_reg   <= (state_reg == IDLE) ? K_W'(1) : cnt_next;
                    sat_reg   <= (state_reg == IDLE) ? 1'b0 : (sat_reg | beat_ovf);
                end
            end
        end
    end

endmodule
